rob_commit_ctrl: RTL and testbench

- Controller for the 64-entry reorder buffer.
- Owns the entry storage (used, destreg, old_destreg, pc, completed) and the head/tail ring pointers.
- Sequences in-order allocation from rename, out-of-order completion marking from the functional units, and in-order retirement to the free list.
- On a flush, walks entries back from the tail, one per cycle, so the rename map can be restored.

---
 rtl/rob_commit_ctrl_if.sv | 57 +++++
 rtl/rob_commit_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_ctrl_if.sv
// Handshake bundle between the reorder buffer controller and rename, the
// functional units, the retire/free-list stage and the flush/rollback path.
interface rob_commit_ctrl_if #(
    parameter int IDX_W  = 6,
    parameter int PREG_W = 6,
    parameter int PC_W   = 32
);
    logic              alloc_valid;
    logic              alloc_ready;
    logic [PREG_W-1:0] alloc_destreg;
    logic [PREG_W-1:0] alloc_old_destreg;
    logic [PC_W-1:0]   alloc_pc;
    logic [IDX_W-1:0]  alloc_rob_idx;

    logic              complete_valid;
    logic [IDX_W-1:0]  complete_idx;

    logic              retire_valid;
    logic              retire_ready;
    logic [PREG_W-1:0] retire_destreg;
    logic [PREG_W-1:0] retire_old_destreg;
    logic [PC_W-1:0]   retire_pc;

    logic              flush_req;
    logic              rollback_valid;
    logic [PREG_W-1:0] rollback_destreg;
    logic [PREG_W-1:0] rollback_old_destreg;
    logic              flush_done;

    logic [IDX_W:0]    rob_count;
    logic              rob_empty;
    logic              rob_full;

    // Pipeline side: rename, FUs, retire consumer and flush source.
    modport master (
        output alloc_valid, alloc_destreg, alloc_old_destreg, alloc_pc,
        output complete_valid, complete_idx,
        output retire_ready,
        output flush_req,
        input  alloc_ready, alloc_rob_idx,
        input  retire_valid, retire_destreg, retire_old_destreg, retire_pc,
        input  rollback_valid, rollback_destreg, rollback_old_destreg, flush_done,
        input  rob_count, rob_empty, rob_full
    );

    // Reorder buffer side.
    modport slave (
        input  alloc_valid, alloc_destreg, alloc_old_destreg, alloc_pc,
        input  complete_valid, complete_idx,
        input  retire_ready,
        input  flush_req,
        output alloc_ready, alloc_rob_idx,
        output retire_valid, retire_destreg, retire_old_destreg, retire_pc,
        output rollback_valid, rollback_destreg, rollback_old_destreg, flush_done,
        output rob_count, rob_empty, rob_full
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer controller: in-order alloc, out-of-order completion, in-order
// retire, and a newest-first rollback walk on flush. ROB_PERF_CNT_EN adds perf counters.
//
// state       | meaning
// ST_RUN      | normal alloc / complete / retire
// ST_ROLLBACK | flush walk, one entry undone per cycle from tail-1 back to head
module rob_commit_ctrl #(
    parameter int ROB_DEPTH = 64,
    parameter int IDX_W     = 6,
    parameter int PREG_W    = 6,
    parameter int PC_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    rob_commit_ctrl_if.slave rob
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]      perf_retired,
    output logic [31:0]      perf_full_stall
`endif
);

    localparam logic [0:0]     ST_RUN      = 1'b0;
    localparam logic [0:0]     ST_ROLLBACK = 1'b1;
    localparam logic [IDX_W:0] CNT_FULL    = (IDX_W+1)'(ROB_DEPTH);
    localparam logic [IDX_W:0] CNT_ONE     = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [0:0]           state;
    logic [IDX_W-1:0]     head;
    logic [IDX_W-1:0]     tail;
    logic [IDX_W:0]       count;
    logic                 flush_done_q;

    logic [ROB_DEPTH-1:0] used;
    logic [ROB_DEPTH-1:0] completed;
    logic [PREG_W-1:0]    destreg_q     [ROB_DEPTH];
    logic [PREG_W-1:0]    old_destreg_q [ROB_DEPTH];
    logic [PC_W-1:0]      pc_q          [ROB_DEPTH];

    logic                 in_run;
    logic                 in_rollback;
    logic                 full;
    logic                 empty;
    logic                 retire_ok;
    logic                 alloc_fire;
    logic                 retire_fire;
    logic                 complete_fire;
    logic [IDX_W-1:0]     tail_prev;

    assign in_run      = (state == ST_RUN);
    assign in_rollback = (state == ST_ROLLBACK);
    assign full        = (count == CNT_FULL);
    assign empty       = (count == '0);
    assign tail_prev   = tail - IDX_ONE;
    assign retire_ok   = in_run && used[head] && completed[head];

    // A flush request freezes every other pipeline action for its cycle.
    assign alloc_fire    = rob.alloc_valid && rob.alloc_ready && !rob.flush_req;
    assign retire_fire   = retire_ok && rob.retire_ready && !rob.flush_req;
    assign complete_fire = in_run && !rob.flush_req && rob.complete_valid
                           && used[rob.complete_idx];

    assign rob.alloc_ready   = reset_n && in_run && !full;
    assign rob.alloc_rob_idx = tail;

    assign rob.retire_valid       = retire_ok;
    assign rob.retire_destreg     = destreg_q[head];
    assign rob.retire_old_destreg = old_destreg_q[head];
    assign rob.retire_pc          = pc_q[head];

    assign rob.rollback_valid       = in_rollback;
    assign rob.rollback_destreg     = in_rollback ? destreg_q[tail_prev] : '0;
    assign rob.rollback_old_destreg = in_rollback ? old_destreg_q[tail_prev] : '0;
    assign rob.flush_done           = flush_done_q;

    assign rob.rob_count = count;
    assign rob.rob_empty = empty;
    assign rob.rob_full  = full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (rob.flush_req) begin
                        // Nothing to undo: acknowledge immediately and stay in RUN.
                        if (empty) begin
                            flush_done_q <= 1'b1;
                        end else begin
                            state <= ST_ROLLBACK;
                        end
                    end else begin
                        if (alloc_fire) begin
                            tail <= tail + IDX_ONE;
                        end
                        if (retire_fire) begin
                            head <= head + IDX_ONE;
                        end
                        if (alloc_fire && !retire_fire) begin
                            count <= count + CNT_ONE;
                        end else if (!alloc_fire && retire_fire) begin
                            count <= count - CNT_ONE;
                        end
                    end
                end
                ST_ROLLBACK: begin
                    tail  <= tail_prev;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state        <= ST_RUN;
                        flush_done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            used      <= '0;
            completed <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                destreg_q[i]     <= '0;
                old_destreg_q[i] <= '0;
                pc_q[i]          <= '0;
            end
        end else begin
            if (alloc_fire) begin
                used[tail]          <= 1'b1;
                completed[tail]     <= 1'b0;
                destreg_q[tail]     <= rob.alloc_destreg;
                old_destreg_q[tail] <= rob.alloc_old_destreg;
                pc_q[tail]          <= rob.alloc_pc;
            end
            if (complete_fire) begin
                completed[rob.complete_idx] <= 1'b1;
            end
            if (retire_fire) begin
                used[head]      <= 1'b0;
                completed[head] <= 1'b0;
            end
            if (in_rollback) begin
                used[tail_prev]      <= 1'b0;
                completed[tail_prev] <= 1'b0;
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Flush leaves these alone; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_retired    <= '0;
            perf_full_stall <= '0;
        end else begin
            if (retire_fire) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (rob.alloc_valid && full) begin
                perf_full_stall <= perf_full_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl (default build, no perf counters).
module tb_rob_commit_ctrl;
    localparam int IDX_W  = 6;
    localparam int PREG_W = 6;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    rob_commit_ctrl_if #(.IDX_W(IDX_W), .PREG_W(PREG_W), .PC_W(PC_W)) rif ();

    rob_commit_ctrl #(
        .ROB_DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .PC_W(PC_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rob    (rif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.alloc_valid       = 1'b0;
        rif.alloc_destreg     = '0;
        rif.alloc_old_destreg = '0;
        rif.alloc_pc          = '0;
        rif.complete_valid    = 1'b0;
        rif.complete_idx      = '0;
        rif.retire_ready      = 1'b0;
        rif.flush_req         = 1'b0;
    endtask

    task automatic drive_alloc(input logic [PC_W-1:0] pc, input logic [PREG_W-1:0] d,
                               input logic [PREG_W-1:0] od);
        rif.alloc_valid       = 1'b1;
        rif.alloc_pc          = pc;
        rif.alloc_destreg     = d;
        rif.alloc_old_destreg = od;
    endtask

    task automatic drive_complete(input int idx);
        rif.complete_valid = 1'b1;
        rif.complete_idx   = IDX_W'(idx);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        idle();
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) step();
        #1;
        n_vec++; if (rif.alloc_ready !== 1'b0) begin n_err++; $display("FAIL rst_alloc_ready: got %0b expected 0", rif.alloc_ready); end
        n_vec++; if (rif.rob_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0b expected 1", rif.rob_empty); end
        n_vec++; if (rif.rob_count !== 7'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", rif.rob_count); end
        n_vec++; if (rif.retire_valid !== 1'b0 || rif.rollback_valid !== 1'b0 || rif.flush_done !== 1'b0)
            begin n_err++; $display("FAIL rst_valids: got rv=%0b rb=%0b fd=%0b expected 0 0 0", rif.retire_valid, rif.rollback_valid, rif.flush_done); end
        n_vec++; if (rif.retire_pc !== 32'd0 || rif.rob_full !== 1'b0 || rif.alloc_rob_idx !== 6'd0)
            begin n_err++; $display("FAIL rst_fields: got pc=%0h full=%0b idx=%0d expected 0 0 0", rif.retire_pc, rif.rob_full, rif.alloc_rob_idx); end
        reset_n = 1'b1;
        #1;
        n_vec++; if (rif.alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0b expected 1", rif.alloc_ready); end
        step();
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 3; i++) begin
            idle();
            drive_alloc(32'h100 + 32'(4 * i), PREG_W'(i + 1), PREG_W'(i + 33));
            #1;
            n_vec++; if (rif.alloc_rob_idx !== IDX_W'(i)) begin n_err++; $display("FAIL alloc_idx[%0d]: got %0d expected %0d", i, rif.alloc_rob_idx, i); end
            step();
        end
        idle();
        #1;
        n_vec++; if (rif.rob_count !== 7'd3) begin n_err++; $display("FAIL alloc_count: got %0d expected 3", rif.rob_count); end
        n_vec++; if (rif.retire_valid !== 1'b0) begin n_err++; $display("FAIL alloc_no_retire: got %0b expected 0", rif.retire_valid); end
    endtask

    task automatic test_inorder_retire();
        idle(); drive_complete(1); #1;
        n_vec++; if (rif.retire_valid !== 1'b0) begin n_err++; $display("FAIL ooo_head_pending: got %0b expected 0", rif.retire_valid); end
        step();
        idle(); drive_complete(0); #1;
        n_vec++; if (rif.retire_valid !== 1'b0) begin n_err++; $display("FAIL ooo_idx1_only: got %0b expected 0", rif.retire_valid); end
        step();
        idle(); rif.retire_ready = 1'b1; #1;
        n_vec++; if (rif.retire_valid !== 1'b1 || rif.retire_pc !== 32'h100 || rif.retire_old_destreg !== 6'd33)
            begin n_err++; $display("FAIL retire0: got v=%0b pc=%0h old=%0d expected 1 100 33", rif.retire_valid, rif.retire_pc, rif.retire_old_destreg); end
        step();
        #1;
        n_vec++; if (rif.retire_valid !== 1'b1 || rif.retire_pc !== 32'h104 || rif.retire_destreg !== 6'd2)
            begin n_err++; $display("FAIL retire1: got v=%0b pc=%0h d=%0d expected 1 104 2", rif.retire_valid, rif.retire_pc, rif.retire_destreg); end
        step();
        repeat (2) step();
        #1;
        n_vec++; if (rif.retire_valid !== 1'b0 || rif.rob_count !== 7'd1)
            begin n_err++; $display("FAIL retire2_held: got v=%0b cnt=%0d expected 0 1", rif.retire_valid, rif.rob_count); end
        drive_complete(2);
        step();
        rif.complete_valid = 1'b0; #1;
        n_vec++; if (rif.retire_valid !== 1'b1 || rif.retire_pc !== 32'h108)
            begin n_err++; $display("FAIL retire2: got v=%0b pc=%0h expected 1 108", rif.retire_valid, rif.retire_pc); end
        step();
        idle(); #1;
        n_vec++; if (rif.rob_empty !== 1'b1) begin n_err++; $display("FAIL retire_empty: got %0b expected 1", rif.rob_empty); end
    endtask

    // head = tail = 3 on entry
    task automatic test_unused_and_hold();
        idle(); drive_complete(10); step();
        idle(); #1;
        n_vec++; if (rif.rob_count !== 7'd0 || rif.retire_valid !== 1'b0)
            begin n_err++; $display("FAIL unused10: got cnt=%0d v=%0b expected 0 0", rif.rob_count, rif.retire_valid); end
        drive_complete(3); step();
        idle(); drive_alloc(32'h200, 6'd7, 6'd39); #1;
        n_vec++; if (rif.alloc_rob_idx !== 6'd3) begin n_err++; $display("FAIL hold_alloc_idx: got %0d expected 3", rif.alloc_rob_idx); end
        step();
        idle(); #1;
        n_vec++; if (rif.retire_valid !== 1'b0 || rif.rob_count !== 7'd1)
            begin n_err++; $display("FAIL unused3_ignored: got v=%0b cnt=%0d expected 0 1", rif.retire_valid, rif.rob_count); end
        drive_complete(3); step();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (rif.retire_valid !== 1'b1 || rif.retire_pc !== 32'h200 || rif.rob_count !== 7'd1)
                begin n_err++; $display("FAIL hold[%0d]: got v=%0b pc=%0h cnt=%0d expected 1 200 1", k, rif.retire_valid, rif.retire_pc, rif.rob_count); end
            step();
        end
        rif.retire_ready = 1'b1; step();
        idle(); #1;
        n_vec++; if (rif.rob_empty !== 1'b1) begin n_err++; $display("FAIL hold_release: got empty=%0b expected 1", rif.rob_empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            drive_alloc(32'(4 * i), PREG_W'(i), PREG_W'(63 - i));
            #1;
            n_vec++; if (rif.alloc_rob_idx !== IDX_W'(i)) begin n_err++; $display("FAIL fill_idx[%0d]: got %0d expected %0d", i, rif.alloc_rob_idx, i); end
            step();
        end
        idle(); #1;
        n_vec++; if (rif.rob_full !== 1'b1 || rif.alloc_ready !== 1'b0 || rif.rob_count !== 7'd64)
            begin n_err++; $display("FAIL full: got full=%0b rdy=%0b cnt=%0d expected 1 0 64", rif.rob_full, rif.alloc_ready, rif.rob_count); end
        drive_alloc(32'h1000, 6'd50, 6'd51); drive_complete(0);
        step();
        #1;
        n_vec++; if (rif.rob_count !== 7'd64) begin n_err++; $display("FAIL full_block: got cnt=%0d expected 64", rif.rob_count); end
        drive_complete(1); rif.retire_ready = 1'b1; #1;
        n_vec++; if (rif.retire_valid !== 1'b1 || rif.alloc_ready !== 1'b0)
            begin n_err++; $display("FAIL full_retire: got v=%0b rdy=%0b expected 1 0", rif.retire_valid, rif.alloc_ready); end
        step();
        rif.complete_valid = 1'b0; #1;
        n_vec++; if (rif.alloc_ready !== 1'b1 || rif.alloc_rob_idx !== 6'd0 || rif.rob_count !== 7'd63 || rif.retire_pc !== 32'd4)
            begin n_err++; $display("FAIL wrap0: got rdy=%0b idx=%0d cnt=%0d pc=%0h expected 1 0 63 4", rif.alloc_ready, rif.alloc_rob_idx, rif.rob_count, rif.retire_pc); end
        step();
        rif.retire_ready = 1'b0; drive_alloc(32'h1004, 6'd52, 6'd53); #1;
        n_vec++; if (rif.alloc_rob_idx !== 6'd1 || rif.rob_count !== 7'd63 || rif.retire_valid !== 1'b0)
            begin n_err++; $display("FAIL wrap1: got idx=%0d cnt=%0d v=%0b expected 1 63 0", rif.alloc_rob_idx, rif.rob_count, rif.retire_valid); end
        step();
        idle(); #1;
        n_vec++; if (rif.rob_full !== 1'b1 || rif.rob_count !== 7'd64)
            begin n_err++; $display("FAIL refull: got full=%0b cnt=%0d expected 1 64", rif.rob_full, rif.rob_count); end
    endtask

    task automatic test_flush();
        do_reset();
        rif.flush_req = 1'b1; step();
        idle(); #1;
        n_vec++; if (rif.flush_done !== 1'b1 || rif.rollback_valid !== 1'b0 || rif.alloc_ready !== 1'b1)
            begin n_err++; $display("FAIL empty_flush: got fd=%0b rb=%0b rdy=%0b expected 1 0 1", rif.flush_done, rif.rollback_valid, rif.alloc_ready); end
        step();
        n_vec++; if (rif.flush_done !== 1'b0) begin n_err++; $display("FAIL empty_flush_pulse: got %0b expected 0", rif.flush_done); end
        for (int i = 0; i < 5; i++) begin
            idle(); drive_alloc(32'h300 + 32'(4 * i), PREG_W'(10 + i), PREG_W'(40 + i)); step();
        end
        idle(); drive_complete(0); step();
        // flush cycle: alloc, complete and a ready retire must all be dropped
        idle(); rif.flush_req = 1'b1; rif.retire_ready = 1'b1; drive_alloc(32'h999, 6'd60, 6'd61); drive_complete(1);
        step();
        idle();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++; if (rif.rollback_valid !== 1'b1 || rif.rollback_destreg !== PREG_W'(14 - k) || rif.rollback_old_destreg !== PREG_W'(44 - k)
                         || rif.rob_count !== 7'(5 - k) || rif.alloc_ready !== 1'b0)
                begin n_err++; $display("FAIL rollback[%0d]: got v=%0b d=%0d od=%0d cnt=%0d rdy=%0b expected 1 %0d %0d %0d 0", k, rif.rollback_valid, rif.rollback_destreg, rif.rollback_old_destreg, rif.rob_count, rif.alloc_ready, 14 - k, 44 - k, 5 - k); end
            rif.flush_req = (k == 1);
            step();
            rif.flush_req = 1'b0;
        end
        #1;
        n_vec++; if (rif.rollback_valid !== 1'b0 || rif.flush_done !== 1'b1 || rif.rob_empty !== 1'b1)
            begin n_err++; $display("FAIL flush_done: got rb=%0b fd=%0b empty=%0b expected 0 1 1", rif.rollback_valid, rif.flush_done, rif.rob_empty); end
        drive_alloc(32'h400, 6'd5, 6'd6); #1;
        n_vec++; if (rif.alloc_rob_idx !== 6'd0 || rif.alloc_ready !== 1'b1)
            begin n_err++; $display("FAIL post_flush_alloc: got idx=%0d rdy=%0b expected 0 1", rif.alloc_rob_idx, rif.alloc_ready); end
        step();
        idle(); #1;
        n_vec++; if (rif.flush_done !== 1'b0 || rif.rob_count !== 7'd1 || rif.retire_valid !== 1'b0)
            begin n_err++; $display("FAIL post_flush_state: got fd=%0b cnt=%0d v=%0b expected 0 1 0", rif.flush_done, rif.rob_count, rif.retire_valid); end
    endtask

    // one entry (idx0) live on entry
    task automatic test_reset_mid_rollback();
        idle(); drive_alloc(32'h500, 6'd20, 6'd30); step();
        idle(); drive_alloc(32'h504, 6'd21, 6'd31); step();
        idle(); rif.flush_req = 1'b1; step();
        idle(); #1;
        n_vec++; if (rif.rollback_valid !== 1'b1 || rif.rollback_destreg !== 6'd21)
            begin n_err++; $display("FAIL mid_rb0: got v=%0b d=%0d expected 1 21", rif.rollback_valid, rif.rollback_destreg); end
        step();
        #1;
        n_vec++; if (rif.rollback_valid !== 1'b1 || rif.rollback_destreg !== 6'd20)
            begin n_err++; $display("FAIL mid_rb1: got v=%0b d=%0d expected 1 20", rif.rollback_valid, rif.rollback_destreg); end
        #1 reset_n = 1'b0;
        #1;
        n_vec++; if (rif.rollback_valid !== 1'b0 || rif.rob_count !== 7'd0 || rif.rob_empty !== 1'b1 || rif.alloc_ready !== 1'b0)
            begin n_err++; $display("FAIL mid_reset: got rb=%0b cnt=%0d empty=%0b rdy=%0b expected 0 0 1 0", rif.rollback_valid, rif.rob_count, rif.rob_empty, rif.alloc_ready); end
        step();
        reset_n = 1'b1; #1;
        n_vec++; if (rif.alloc_ready !== 1'b1 || rif.alloc_rob_idx !== 6'd0 || rif.flush_done !== 1'b0)
            begin n_err++; $display("FAIL mid_release: got rdy=%0b idx=%0d fd=%0b expected 1 0 0", rif.alloc_ready, rif.alloc_rob_idx, rif.flush_done); end
        step();
        #1;
        n_vec++; if (rif.rollback_valid !== 1'b0 || rif.flush_done !== 1'b0)
            begin n_err++; $display("FAIL mid_after: got rb=%0b fd=%0b expected 0 0", rif.rollback_valid, rif.flush_done); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_inorder_retire();
        test_unused_and_hold();
        test_full_wrap();
        test_flush();
        test_reset_mid_rollback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
